tmds_deserializer: RTL and testbench
====================================

Name: tmds_deserializer

Overview:
Receive-side counterpart of the TMDS serializer. Takes the 2-bit-per-clock serial stream in the shift-clock domain and rebuilds 10-bit TMDS symbols. Finds word alignment by hunting for TMDS control tokens, confirms lock, and reports decoded control codes and loss of lock. Feeds a downstream TMDS decoder or loopback checker.

Parameters:
CTRL_CONFIRM, 8, consecutive aligned control tokens required to move from CONFIRM to LOCKED (range 1..255).
MAX_GAP, 4096, emitted words without a control token before lock is dropped (range 16..65535).

Ports:
i_clk_shift  in  1  shift clock; one 2-bit pair per cycle.
i_rst  in  1  synchronous reset, active-high.
i_data  in  2  serial pair; i_data[0] is the earlier bit; stream is LSB-first per symbol.
i_resync  in  1  one-cycle pulse; forces re-alignment.
o_data  out  10  aligned symbol.
o_valid  out  1  one-cycle strobe, o_data valid; asserted only in LOCKED.
o_is_ctrl  out  1  o_data is one of the 4 control tokens; qualified by o_valid.
o_ctrl  out  2  decoded {c1,c0} when o_is_ctrl: 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11; else 00.
o_locked  out  1  high in LOCKED state.

Behaviour:
- Reset value of all outputs is 0. FSM resets to SEARCH. sr, phase, slip, counters reset to 0.
- sr[11:0] is a history register, updated every cycle with sr <= {i_data[1], i_data[0], sr[11:2]}.
- Candidate words (evaluated on the updated sr): cand0 = sr[11:2] (ends on i_data[1]); cand1 = sr[10:1] (ends on i_data[0]). The selected word is cand1 when slip=1, else cand0.
- phase is a 0..4 counter. A word is taken when phase==4, and phase then wraps to 0. Latency: the word whose last bit arrives in cycle N is on o_data with o_valid in cycle N+1.
- SEARCH:
  - Each cycle, test cand0, then cand1, against the token set.
  - First match: slip <= (cand0 failed), phase <= 0, cnt <= 1, go to CONFIRM.
  - If both match (impossible for legal tokens), cand0 wins.
- CONFIRM:
  - At each word boundary, a token increments cnt. When cnt reaches CTRL_CONFIRM, go to LOCKED and clear gap.
  - A non-token word sends the FSM back to SEARCH.
  - o_valid stays 0 in this state.
- LOCKED:
  - o_valid pulses every 5th cycle, with o_data, o_is_ctrl and o_ctrl registered.
  - The gap counter clears on each token and increments on each non-token.
  - When gap reaches MAX_GAP, go to SEARCH. o_locked falls in the same cycle that the final o_valid is emitted.
  - slip and phase are frozen; no realignment happens while locked.
- i_resync in any state: next state is SEARCH, and o_valid is suppressed that cycle. i_resync has priority over a simultaneous lock transition.
- CTRL_CONFIRM=1: the first matching token moves SEARCH to CONFIRM, and the next boundary token moves CONFIRM to LOCKED.
- i_rst mid-word: the partial word is discarded with no o_valid, and search restarts from an empty sr, so the first possible match is 5 cycles after release.
- All counters saturate and never wrap.

Optional Feature:
DESER_ERR_CNT_EN:
- When defined, adds port o_err_cnt (out, 16 bits).
- o_err_cnt is a saturating count of LOCKED->SEARCH transitions caused by MAX_GAP or i_resync. It is cleared only by i_rst.
- When undefined, the port and its counter are absent, with no other change.

Test Plan:
- Token 1101010100 repeated, bit offset 0, CTRL_CONFIRM=8 -> o_locked rises after 8 words. Every o_valid has o_data=1101010100, o_is_ctrl=1, o_ctrl=00, and valids are exactly 5 cycles apart.
- Same stream delayed by 1 bit (odd offset) -> slip=1, lock achieved, o_data=1101010100. Repeat for delays of 2..9 bits -> lock and correct data for every offset.
- 8 x token 1010101011 then alternating data 0111110000 / token 0010101011 -> o_ctrl=11, then data words with o_is_ctrl=0, then o_ctrl=01. Lock is held throughout.
- MAX_GAP=16: lock, then 16 consecutive data words -> o_locked falls with the 16th o_valid. With DESER_ERR_CNT_EN, o_err_cnt=1.
- In CONFIRM with cnt=3, inject data word 0000011111 -> back to SEARCH, o_valid never asserted. Re-lock needs 8 new tokens.
- Pulse i_resync while LOCKED, and separately pulse i_rst mid-word -> o_valid/o_locked drop next cycle, all outputs 0 after reset, and re-lock occurs after 8 tokens.

Source files
------------

// File: rtl/tmds_deserializer.sv
// rtl/tmds_deserializer.sv - 2-bit-per-clock TMDS symbol aligner locking on control tokens
// Optional DESER_ERR_CNT_EN adds o_err_cnt, a saturating count of lock losses.
module tmds_deserializer #(
  parameter int CTRL_CONFIRM = 8,
  parameter int MAX_GAP      = 4096
) (
  input  logic        i_clk_shift,
  input  logic        i_rst,
  input  logic [1:0]  i_data,
  input  logic        i_resync,
  output logic [9:0]  o_data,
  output logic        o_valid,
  output logic        o_is_ctrl,
  output logic [1:0]  o_ctrl,
`ifdef DESER_ERR_CNT_EN
  output logic [15:0] o_err_cnt,
`endif
  output logic        o_locked
);

  localparam logic [7:0]  CONFIRM_N = 8'(CTRL_CONFIRM);
  localparam logic [15:0] GAP_N     = 16'(MAX_GAP);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_e;

  // Returns {is_ctrl, c1, c0}
  function automatic logic [2:0] tok_decode(input logic [9:0] w);
    case (w)
      10'b1101010100: tok_decode = 3'b100;
      10'b0010101011: tok_decode = 3'b101;
      10'b0101010100: tok_decode = 3'b110;
      10'b1010101011: tok_decode = 3'b111;
      default:        tok_decode = 3'b000;
    endcase
  endfunction

  state_e      state_q, state_d;
  // Only the history bits that can still reach a candidate word are stored.
  logic [11:3] sr_q;
  logic [11:1] sr_d;
  logic [2:0]  phase_q, phase_d;
  logic        slip_q, slip_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] gap_q, gap_d, gap_inc;
  logic        valid_q, valid_d;
  logic [9:0]  data_q;
  logic        is_ctrl_q;
  logic [1:0]  ctrl_q;

  logic [9:0]  cand0, cand1, word;
  logic [2:0]  dec0, dec1, word_dec;
  logic        boundary;

  always_comb begin
    sr_d     = {i_data[1], i_data[0], sr_q[11:3]};
    cand0    = sr_d[11:2];
    cand1    = sr_d[10:1];
    dec0     = tok_decode(cand0);
    dec1     = tok_decode(cand1);
    word     = slip_q ? cand1 : cand0;
    word_dec = slip_q ? dec1 : dec0;
    boundary = (phase_q == 3'd4);
    cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    gap_inc  = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;

    state_d  = state_q;
    slip_d   = slip_q;
    phase_d  = boundary ? 3'd0 : phase_q + 3'd1;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    valid_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        phase_d = 3'd0;
        if (dec0[2] || dec1[2]) begin
          slip_d  = !dec0[2];
          cnt_d   = 8'd1;
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (boundary) begin
          if (word_dec[2]) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CONFIRM_N) begin
              state_d = LOCKED;
              gap_d   = 16'd0;
            end
          end else begin
            state_d = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          valid_d = 1'b1;
          if (word_dec[2]) begin
            gap_d = 16'd0;
          end else begin
            gap_d = gap_inc;
            if (gap_inc >= GAP_N) state_d = SEARCH;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (i_resync) begin
      state_d = SEARCH;
      valid_d = 1'b0;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge i_clk_shift) begin
    if (i_rst) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      phase_q   <= '0;
      slip_q    <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      is_ctrl_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d[11:3];
      phase_q <= phase_d;
      slip_q  <= slip_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      if (valid_d) begin
        data_q    <= word;
        is_ctrl_q <= word_dec[2];
        ctrl_q    <= word_dec[1:0];
      end
    end
  end

`ifdef DESER_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        lock_lost;

  // LOCKED only ever exits through a gap timeout or i_resync.
  assign lock_lost = (state_q == LOCKED) && (state_d == SEARCH);

  always_ff @(posedge i_clk_shift) begin
    if (i_rst) begin
      err_cnt_q <= '0;
    end else if (lock_lost && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`endif

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_is_ctrl = is_ctrl_q;
  assign o_ctrl    = ctrl_q;
  assign o_locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_tmds_deserializer.sv
// tb/tb_tmds_deserializer.sv - directed self-checking bench for tmds_deserializer
module tb_tmds_deserializer;

  localparam logic [9:0] TOK00  = 10'b1101010100;
  localparam logic [9:0] TOK01  = 10'b0010101011;
  localparam logic [9:0] TOK11  = 10'b1010101011;
  localparam logic [9:0] DATA_A = 10'b0111110000;
  localparam logic [9:0] DATA_B = 10'b0000011111;

  typedef struct {
    int          cyc;
    logic [12:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_resync = 1'b0;
  logic [1:0] i_data = 2'b00;
  logic [9:0] o_data, o_data1;
  logic       o_valid, o_valid1, o_is_ctrl, o_is_ctrl1, o_locked, o_locked1;
  logic [1:0] o_ctrl, o_ctrl1;
`ifdef DESER_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt1;
`endif

  tmds_deserializer #(.CTRL_CONFIRM(8), .MAX_GAP(16)) u_dut (
    .i_clk_shift (clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_resync    (i_resync),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_is_ctrl   (o_is_ctrl),
    .o_ctrl      (o_ctrl),
`ifdef DESER_ERR_CNT_EN
    .o_err_cnt   (err_cnt),
`endif
    .o_locked    (o_locked)
  );

  tmds_deserializer #(.CTRL_CONFIRM(1)) u_dut1 (
    .i_clk_shift (clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_resync    (i_resync),
    .o_data      (o_data1),
    .o_valid     (o_valid1),
    .o_is_ctrl   (o_is_ctrl1),
    .o_ctrl      (o_ctrl1),
`ifdef DESER_ERR_CNT_EN
    .o_err_cnt   (err_cnt1),
`endif
    .o_locked    (o_locked1)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          bits[$];
  exp_t        exp_q[$];
  int          cyc, nbits, nvalid, rst_at, resync_at;
  int          lock_cyc, drop_cyc, relock_cyc, lock1_cyc, v1_cyc;
  logic        prev_locked;
  logic [12:0] v1_word;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [9:0] w, input bit want, input logic [2:0] dec);
    exp_t e;
    for (int i = 0; i < 10; i++) bits.push_back(w[i]);
    nbits += 10;
    if (want) begin
      e.cyc = (nbits - 1) / 2 + 1;
      e.w   = {dec, w};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) bits.push_back(1'b0);
    nbits += n;
  endtask

  task automatic step();
    exp_t e;
    i_data[0] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
    i_data[1] = (bits.size() > 0) ? bits.pop_front() : 1'b0;
    i_rst     = (cyc + 1 == rst_at);
    i_resync  = (cyc + 1 == resync_at);
    @(posedge clk);
    #1;
    cyc++;
    if (o_locked && !prev_locked) begin
      if (lock_cyc < 0) lock_cyc = cyc;
      else relock_cyc = cyc;
    end
    if (!o_locked && prev_locked && drop_cyc < 0) drop_cyc = cyc;
    prev_locked = o_locked;
    if (o_locked1 && lock1_cyc < 0) lock1_cyc = cyc;
    if (o_valid1 && v1_cyc < 0) begin
      v1_cyc  = cyc;
      v1_word = {o_is_ctrl1, o_ctrl1, o_data1};
    end
    if (cyc == rst_at) begin
      check_eq("midrst_outputs", {o_valid, o_locked, o_is_ctrl, o_ctrl, o_data}, 0);
    end
    if (o_valid) begin
      nvalid++;
      check_eq("valid_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("valid_cycle", cyc, e.cyc);
        check_eq("valid_word", {o_is_ctrl, o_ctrl, o_data}, e.w);
      end
    end
  endtask

  task automatic run();
    while (bits.size() > 0) step();
    repeat (2) step();
  endtask

  task automatic do_reset();
    bits.delete();
    exp_q.delete();
    i_rst    = 1'b1;
    i_data   = 2'b00;
    i_resync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst       = 1'b0;
    cyc         = 0;
    nbits       = 0;
    nvalid      = 0;
    rst_at      = -1;
    resync_at   = -1;
    lock_cyc    = -1;
    drop_cyc    = -1;
    relock_cyc  = -1;
    lock1_cyc   = -1;
    v1_cyc      = -1;
    v1_word     = '0;
    prev_locked = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_data", o_data, 0);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_locked", o_locked, 0);
    check_eq("rst_ctrl", {o_is_ctrl, o_ctrl}, 0);
`ifdef DESER_ERR_CNT_EN
    check_eq("rst_err_cnt", err_cnt, 0);
`endif

    // Aligned token 00 stream
    repeat (8) push_word(TOK00, 0, 3'b000);
    repeat (4) push_word(TOK00, 1, 3'b100);
    run();
    check_eq("s1_lock_cyc", lock_cyc, 40);
    check_eq("s1_nvalid", nvalid, 4);
    check_eq("s1_exp_left", exp_q.size(), 0);
    check_eq("s1_c1_lock_cyc", lock1_cyc, 10);
    check_eq("s1_c1_first_valid", v1_cyc, 15);
    check_eq("s1_c1_word", v1_word, {3'b100, TOK00});
`ifdef DESER_ERR_CNT_EN
    check_eq("s1_c1_err_cnt", err_cnt1, 0);
`endif

    // Every bit offset 1..9
    for (int d = 1; d <= 9; d++) begin
      do_reset();
      push_zeros(d);
      repeat (8) push_word(TOK00, 0, 3'b000);
      repeat (2) push_word(TOK00, 1, 3'b100);
      run();
      check_eq($sformatf("s2_lock_cyc_d%0d", d), lock_cyc, (d + 79) / 2 + 1);
      check_eq($sformatf("s2_nvalid_d%0d", d), nvalid, 2);
    end

    // Token 11 lock, then alternating data / token 01
    do_reset();
    repeat (8) push_word(TOK11, 0, 3'b000);
    push_word(TOK11, 1, 3'b111);
    repeat (4) begin
      push_word(DATA_A, 1, 3'b000);
      push_word(TOK01, 1, 3'b101);
    end
    run();
    check_eq("s3_lock_cyc", lock_cyc, 40);
    check_eq("s3_lock_held", drop_cyc, -1);
    check_eq("s3_nvalid", nvalid, 9);
    check_eq("s3_exp_left", exp_q.size(), 0);

    // Gap timeout after 16 data words
    do_reset();
    repeat (8) push_word(TOK00, 0, 3'b000);
    push_word(TOK00, 1, 3'b100);
    repeat (16) push_word(DATA_A, 1, 3'b000);
    repeat (2) push_word(DATA_A, 0, 3'b000);
    run();
    check_eq("s4_drop_cyc", drop_cyc, 125);
    check_eq("s4_nvalid", nvalid, 17);
    check_eq("s4_exp_left", exp_q.size(), 0);
`ifdef DESER_ERR_CNT_EN
    check_eq("s4_err_cnt", err_cnt, 1);
`endif

    // Data word while confirming (cnt=3)
    do_reset();
    repeat (3) push_word(TOK00, 0, 3'b000);
    push_word(DATA_B, 0, 3'b000);
    repeat (8) push_word(TOK00, 0, 3'b000);
    repeat (2) push_word(TOK00, 1, 3'b100);
    run();
    check_eq("s5_lock_cyc", lock_cyc, 60);
    check_eq("s5_nvalid", nvalid, 2);

    // Resync pulse on a locked word boundary
    do_reset();
    repeat (8) push_word(TOK00, 0, 3'b000);
    push_word(TOK00, 1, 3'b100);
    push_word(TOK00, 0, 3'b000);
    repeat (8) push_word(TOK00, 0, 3'b000);
    repeat (2) push_word(TOK00, 1, 3'b100);
    resync_at = 50;
    run();
    check_eq("s6_drop_cyc", drop_cyc, 50);
    check_eq("s6_relock_cyc", relock_cyc, 90);
    check_eq("s6_nvalid", nvalid, 3);
`ifdef DESER_ERR_CNT_EN
    check_eq("s6_err_cnt", err_cnt, 1);
`endif

    // Reset pulse mid-word
    do_reset();
    repeat (8) push_word(TOK00, 0, 3'b000);
    push_word(TOK00, 1, 3'b100);
    repeat (9) push_word(TOK00, 0, 3'b000);
    push_word(TOK00, 1, 3'b100);
    rst_at = 47;
    run();
    check_eq("s7_drop_cyc", drop_cyc, 47);
    check_eq("s7_relock_cyc", relock_cyc, 90);
    check_eq("s7_nvalid", nvalid, 2);
`ifdef DESER_ERR_CNT_EN
    check_eq("s7_err_cnt", err_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
